// File: rtl/data_register.sv
// rtl/data_register.sv - parameterised retiming register / N-stage delay line
module data_register #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_STAGES  = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT
);

  // Refuse to build a zero-width word or a zero-depth pipeline.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("data_register: DATA_WIDTH must be >= 1");
  end
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("data_register: NUM_STAGES must be >= 1");
  end

  // stage_q[0] is the capture flop, stage_q[NUM_STAGES-1] feeds the output.
  logic [DATA_WIDTH-1:0] stage_q [NUM_STAGES];

  // Shift the word stream one stage per edge; reset clears all stages at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= DATA_IN;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Output comes straight off the last flop, no logic in between.
  assign DATA_OUT = stage_q[NUM_STAGES-1];

endmodule

// File: tb/tb_data_register.sv
// tb/tb_data_register.sv - randomized self-checking bench for data_register
module tb_data_register;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [15:0] din_a, dout_a;   // 16 bits, 1 stage, reset 0
  logic [15:0] din_b, dout_b;   // 16 bits, 3 stages, reset DEAD
  logic        din_c, dout_c;   // 1 bit, 1 stage
  logic [63:0] din_d, dout_d;   // 64 bits, 2 stages

  int total = 0;
  int bad   = 0;

  // Reference: each queue holds the words the pipeline still owes; front is next out.
  logic [63:0] qa[$], qb[$], qc[$], qd[$];

  data_register #(.DATA_WIDTH(16), .NUM_STAGES(1)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(din_a), .DATA_OUT(dout_a));
  data_register #(.DATA_WIDTH(16), .NUM_STAGES(3), .RESET_VALUE(16'hDEAD)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(din_b), .DATA_OUT(dout_b));
  data_register #(.DATA_WIDTH(1), .NUM_STAGES(1)) dut_c (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(din_c), .DATA_OUT(dout_c));
  data_register #(.DATA_WIDTH(64), .NUM_STAGES(2)) dut_d (
    .CLK(CLK), .RSTN(RSTN), .DATA_IN(din_d), .DATA_OUT(dout_d));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    qa = {};
    qb = {};
    qc = {};
    qd = {};
    qa.push_back(64'h0);
    for (int i = 0; i < 3; i++) qb.push_back(64'hDEAD);
    qc.push_back(64'h0);
    for (int i = 0; i < 2; i++) qd.push_back(64'h0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a"}, 64'(dout_a), qa[0]);
    check({tag, "_b"}, 64'(dout_b), qb[0]);
    check({tag, "_c"}, 64'(dout_c), qc[0]);
    check({tag, "_d"}, dout_d, qd[0]);
  endtask

  // One clock: advance the reference when out of reset, then check 1ns after the edge.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RSTN) begin
      qa.push_back(64'(din_a)); void'(qa.pop_front());
      qb.push_back(64'(din_b)); void'(qb.pop_front());
      qc.push_back(64'(din_c)); void'(qc.pop_front());
      qd.push_back(din_d);      void'(qd.pop_front());
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive_random();
    din_a = 16'($urandom);
    din_b = 16'($urandom);
    din_c = 1'($urandom);
    din_d = {$urandom, $urandom};
  endtask

  initial begin
    model_reset();
    din_a = 16'hFFFF;
    din_b = 16'hFFFF;
    din_c = 1'b1;
    din_d = '1;

    // Held in reset with all-ones input: outputs stay at reset values.
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check("rst_a", 64'(dout_a), 64'h0000);
      check("rst_b", 64'(dout_b), 64'hDEAD);
      check("rst_c", 64'(dout_c), 64'h0);
      check("rst_d", dout_d, 64'h0);
    end

    // Release mid-cycle, then idle zeros for 4 cycles.
    @(negedge CLK);
    RSTN  = 1'b1;
    din_a = '0;
    din_b = '0;
    din_c = 1'b0;
    din_d = '0;
    for (int i = 0; i < 4; i++) tick("idle");

    // Single-word latency plus the deep-pipe and wide-word patterns.
    din_a = 16'hA5C3;
    din_b = 16'h0001;
    din_c = 1'b1;
    din_d = 64'h8000_0000_0000_0001;
    #1;
    check("lat_before", 64'(dout_a), 64'h0000);
    tick("lat");
    check("lat_at", 64'(dout_a), 64'hA5C3);
    din_a = '0;
    din_b = '0;
    din_d = '0;
    for (int i = 0; i < 4; i++) begin
      din_c = 1'(i);
      tick("pipe");
      if (i == 1) check("deep_word", 64'(dout_b), 64'h0001);
      if (i == 0) check("wide_word", dout_d, 64'h8000_0000_0000_0001);
    end

    // Random stream.
    for (int i = 0; i < 10; i++) begin
      drive_random();
      tick("rand");
    end

    // Async reset mid-stream while the 1-stage output shows 1234.
    din_a = 16'h1234;
    tick("pre_rst");
    check("pre_rst_1234", 64'(dout_a), 64'h1234);
    drive_random();
    #2;
    RSTN = 1'b0;
    #1;
    check("async_a", 64'(dout_a), 64'h0000);
    check("async_b", 64'(dout_b), 64'hDEAD);
    check("async_d", dout_d, 64'h0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random();
      tick("hold_rst");
    end
    @(negedge CLK);
    RSTN = 1'b1;

    // Stream after release: reset values drain out before new words.
    for (int i = 0; i < 12; i++) begin
      drive_random();
      tick("post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
